// File: rtl/topk_result_buffer_if.sv
// topk_result_buffer_if: candidate insert, result drain and status signals of topk_result_buffer.
interface topk_result_buffer_if #(
    parameter int K          = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
);
    localparam int CW = $clog2(K + 1);
    logic                  clear_in;
    logic                  ins_valid_in;
    logic                  ins_ready_out;
    logic [DATA_WIDTH-1:0] ins_data_in;
    logic [TAG_WIDTH-1:0]  ins_tag_in;
    logic                  flush_in;
    logic                  out_valid_out;
    logic                  out_ready_in;
    logic [DATA_WIDTH-1:0] out_data_out;
    logic [TAG_WIDTH-1:0]  out_tag_out;
    logic                  out_last_out;
    logic [CW-1:0]         count_out;
    logic                  full_out;
    logic [TAG_WIDTH-1:0]  worst_tag_out;
    logic                  done_out;
    modport master (
        output clear_in, ins_valid_in, ins_data_in, ins_tag_in, flush_in, out_ready_in,
        input  ins_ready_out, out_valid_out, out_data_out, out_tag_out, out_last_out,
               count_out, full_out, worst_tag_out, done_out
    );
    modport slave (
        input  clear_in, ins_valid_in, ins_data_in, ins_tag_in, flush_in, out_ready_in,
        output ins_ready_out, out_valid_out, out_data_out, out_tag_out, out_last_out,
               count_out, full_out, worst_tag_out, done_out
    );
endinterface

// File: rtl/topk_result_buffer.sv
// topk_result_buffer: keeps the K smallest-tag candidates sorted and drains them in order.
// Define TOPK_DEDUP_EN to drop candidates whose address already sits in a valid slot.
module topk_result_buffer #(
    parameter int K          = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    topk_result_buffer_if.slave bus
);
    localparam int CW = $clog2(K + 1);
    typedef enum logic {FILL, DRAIN} state_e;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q [K];
    logic [DATA_WIDTH-1:0] data_d [K];
    logic [TAG_WIDTH-1:0]  tag_q [K];
    logic [TAG_WIDTH-1:0]  tag_d [K];
    logic [CW-1:0]         cnt_q, cnt_d, cnt_ins, rd_q, rd_d, pos, nxt;
    logic                  ov_q, ov_d, ol_q, ol_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] od_q, od_d, rd_data;
    logic [TAG_WIDTH-1:0]  ot_q, ot_d, rd_tag;
    logic                  full, fire, keep, dup, last_xfer;
    // Slots are sorted, so the insert point is one past the last slot whose tag is <= the candidate.
    always_comb begin
        pos = '0;
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (CW'(i) < cnt_q && tag_q[i] <= bus.ins_tag_in) pos = CW'(i + 1);
`ifdef TOPK_DEDUP_EN
            if (CW'(i) < cnt_q && data_q[i] == bus.ins_data_in) dup = 1'b1;
`endif
        end
    end
    always_comb begin
        fire    = bus.ins_valid_in && bus.ins_ready_out;
        keep    = fire && !dup && (!full || bus.ins_tag_in < tag_q[K-1]);
        cnt_ins = keep && !full ? cnt_q + 1'b1 : cnt_q;
        for (int i = 0; i < K; i++) begin
            data_d[i] = !keep || CW'(i) < pos ? data_q[i] : CW'(i) == pos ? bus.ins_data_in : data_q[i > 0 ? i - 1 : 0];
            tag_d[i]  = !keep || CW'(i) < pos ? tag_q[i] : CW'(i) == pos ? bus.ins_tag_in : tag_q[i > 0 ? i - 1 : 0];
        end
    end
    always_comb begin
        nxt       = rd_q + 1'b1;
        last_xfer = rd_q == cnt_q - 1'b1;
        rd_data   = '0;
        rd_tag    = '0;
        for (int i = 0; i < K; i++) begin
            if (CW'(i) == nxt) begin
                rd_data = data_q[i];
                rd_tag  = tag_q[i];
            end
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= FILL;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_ins;
        rd_d    = rd_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        od_d    = od_q;
        ot_d    = ot_q;
        done_d  = 1'b0;
        if (bus.clear_in) begin
            state_d = FILL;
            cnt_d   = '0;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
        end else if (state_q == FILL && bus.flush_in) begin
            // The same-cycle insert is already folded into cnt_ins and the _d slots.
            done_d  = cnt_ins == '0;
            state_d = cnt_ins == '0 ? FILL : DRAIN;
            ov_d    = cnt_ins != '0;
            ol_d    = cnt_ins == CW'(1);
            rd_d    = '0;
            od_d    = data_d[0];
            ot_d    = tag_d[0];
        end else if (state_q == DRAIN && ov_q && bus.out_ready_in) begin
            state_d = last_xfer ? FILL : DRAIN;
            cnt_d   = last_xfer ? '0 : cnt_q;
            done_d  = last_xfer;
            ov_d    = !last_xfer;
            ol_d    = !last_xfer && nxt == cnt_q - 1'b1;
            rd_d    = last_xfer ? rd_q : nxt;
            od_d    = last_xfer ? od_q : rd_data;
            ot_d    = last_xfer ? ot_q : rd_tag;
        end
    end
    always_comb begin
        full              = cnt_q == CW'(K);
        bus.ins_ready_out = state_q == FILL && !bus.clear_in;
        bus.full_out      = full;
        bus.worst_tag_out = full ? tag_q[K-1] : '1;
        bus.count_out     = cnt_q;
        bus.out_valid_out = ov_q;
        bus.out_last_out  = ol_q;
        bus.out_data_out  = od_q;
        bus.out_tag_out   = ot_q;
        bus.done_out      = done_q;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            rd_q   <= '0;
            ov_q   <= 1'b0;
            ol_q   <= 1'b0;
            done_q <= 1'b0;
            od_q   <= '0;
            ot_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            ov_q   <= ov_d;
            ol_q   <= ol_d;
            done_q <= done_d;
            od_q   <= od_d;
            ot_q   <= ot_d;
        end
    end
    // Slot storage is left unreset; cnt_q alone decides which slots are meaningful.
    always_ff @(posedge clk_in) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end
endmodule

// File: tb/tb_topk_result_buffer.sv
// tb_topk_result_buffer: directed scenarios plus random traffic checked against a sorted-queue model.
module tb_topk_result_buffer;
    localparam int K  = 4;
    localparam int DW = 16;
    localparam int TW = 8;
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ent_t;
    logic clk, rst_n;
    int vectors, miscompares;
    ent_t mq[$];
    bit m_drain, m_done;
    int m_idx;
    logic [TW-1:0] got[$];
    int lastpos;
    bit done_seen;
    topk_result_buffer_if #(.K(K), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
    topk_result_buffer #(.K(K), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic m_insert(input logic [DW-1:0] d, input logic [TW-1:0] t);
        ent_t e;
        int p;
`ifdef TOPK_DEDUP_EN
        foreach (mq[i]) if (mq[i].d == d) return;
`endif
        if (mq.size() == K && t >= mq[K-1].t) return;
        p = 0;
        while (p < mq.size() && mq[p].t <= t) p++;
        e.d = d;
        e.t = t;
        mq.insert(p, e);
        if (mq.size() > K) void'(mq.pop_back());
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_drain = 0;
            m_done  = 0;
            m_idx   = 0;
        end else begin
            m_done = 0;
            if (bus.clear_in) begin
                mq.delete();
                m_drain = 0;
            end else if (!m_drain) begin
                if (bus.ins_valid_in) m_insert(bus.ins_data_in, bus.ins_tag_in);
                if (bus.flush_in) begin
                    if (mq.size() == 0) m_done = 1;
                    else begin
                        m_drain = 1;
                        m_idx   = 0;
                    end
                end
            end else if (bus.out_ready_in) begin
                if (m_idx == mq.size() - 1) begin
                    m_drain = 0;
                    mq.delete();
                    m_done = 1;
                end else m_idx++;
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic compare_model();
        chk("ready", bus.ins_ready_out, !m_drain && !bus.clear_in);
        chk("valid", bus.out_valid_out, m_drain);
        chk("last", bus.out_last_out, m_drain && m_idx == mq.size() - 1);
        chk("count", bus.count_out, mq.size());
        chk("full", bus.full_out, mq.size() == K);
        chk("worst", bus.worst_tag_out, mq.size() == K ? mq[K-1].t : {TW{1'b1}});
        chk("done", bus.done_out, m_done);
        if (m_drain) begin
            chk("data", bus.out_data_out, mq[m_idx].d);
            chk("tag", bus.out_tag_out, mq[m_idx].t);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) compare_model();
    endtask
    task automatic ins(input logic [DW-1:0] d, input logic [TW-1:0] t);
        bus.ins_valid_in = 1'b1;
        bus.ins_data_in  = d;
        bus.ins_tag_in   = t;
        tick();
        bus.ins_valid_in = 1'b0;
    endtask
    task automatic flush();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
    endtask
    task automatic clear();
        bus.clear_in = 1'b1;
        tick();
        bus.clear_in = 1'b0;
    endtask
    task automatic collect();
        got.delete();
        lastpos   = -1;
        done_seen = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (bus.done_out) done_seen = 1;
            else begin
                if (bus.out_valid_out && bus.out_ready_in) begin
                    got.push_back(bus.out_tag_out);
                    if (bus.out_last_out) lastpos = got.size() - 1;
                end
                tick();
            end
        end
        chk("drain_done_seen", done_seen, 1);
    endtask
    task automatic chk_reset_vals(input string name);
        chk({name, "_valid"}, bus.out_valid_out, 0);
        chk({name, "_last"}, bus.out_last_out, 0);
        chk({name, "_done"}, bus.done_out, 0);
        chk({name, "_count"}, bus.count_out, 0);
        chk({name, "_full"}, bus.full_out, 0);
        chk({name, "_data"}, bus.out_data_out, 0);
        chk({name, "_tag"}, bus.out_tag_out, 0);
        chk({name, "_worst"}, bus.worst_tag_out, {TW{1'b1}});
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.clear_in = 0;
        bus.ins_valid_in = 0;
        bus.ins_data_in = '0;
        bus.ins_tag_in = '0;
        bus.flush_in = 0;
        bus.out_ready_in = 0;
        #3;
        chk_reset_vals("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // Unordered inserts drain in ascending order.
        ins(16'h0109, 8'd9);
        ins(16'h0103, 8'd3);
        ins(16'h0107, 8'd7);
        ins(16'h0105, 8'd5);
        flush();
        bus.out_ready_in = 1'b1;
        collect();
        chk("r34_n", got.size(), 4);
        if (got.size() == 4) begin
            chk("r34_t0", got[0], 3);
            chk("r34_t1", got[1], 5);
            chk("r34_t2", got[2], 7);
            chk("r34_t3", got[3], 9);
        end
        chk("r34_lastpos", lastpos, 3);
        chk("r34_count", bus.count_out, 0);
        tick();
        chk("r34_done_once", bus.done_out, 0);
        // Full buffer: better candidate displaces the worst, tie with worst is discarded.
        bus.out_ready_in = 1'b0;
        ins(16'h0203, 8'd3);
        ins(16'h0205, 8'd5);
        ins(16'h0207, 8'd7);
        ins(16'h0209, 8'd9);
        chk("r35_full", bus.full_out, 1);
        chk("r35_worst9", bus.worst_tag_out, 9);
        ins(16'h0204, 8'd4);
        chk("r35_worst7", bus.worst_tag_out, 7);
        chk("r35_count", bus.count_out, 4);
        ins(16'h0277, 8'd7);
        chk("r35_worst_keep", bus.worst_tag_out, 7);
        flush();
        bus.out_ready_in = 1'b1;
        collect();
        chk("r35_n", got.size(), 4);
        if (got.size() == 4) begin
            chk("r35_t0", got[0], 3);
            chk("r35_t1", got[1], 4);
            chk("r35_t2", got[2], 5);
            chk("r35_t3", got[3], 7);
        end
        // Backpressure holds the presented entry.
        bus.out_ready_in = 1'b0;
        ins(16'h0308, 8'd8);
        ins(16'h0302, 8'd2);
        ins(16'h0306, 8'd6);
        flush();
        for (int c = 0; c < 5; c++) begin
            chk("r36_hold_valid", bus.out_valid_out, 1);
            chk("r36_hold_data", bus.out_data_out, 16'h0302);
            chk("r36_hold_tag", bus.out_tag_out, 2);
            tick();
        end
        bus.out_ready_in = 1'b1;
        collect();
        chk("r36_n", got.size(), 3);
        chk("r36_lastpos", lastpos, 2);
        chk("r36_count", bus.count_out, 0);
        // Empty flush, then clear in the middle of a drain.
        bus.out_ready_in = 1'b0;
        tick();
        flush();
        chk("r37_empty_done", bus.done_out, 1);
        chk("r37_empty_valid", bus.out_valid_out, 0);
        tick();
        chk("r37_empty_done_once", bus.done_out, 0);
        ins(16'h0401, 8'd1);
        ins(16'h0402, 8'd2);
        flush();
        tick();
        clear();
        chk("r37_clr_valid", bus.out_valid_out, 0);
        chk("r37_clr_count", bus.count_out, 0);
        chk("r37_clr_done", bus.done_out, 0);
        tick();
        chk("r37_clr_done2", bus.done_out, 0);
        // Same address twice.
        ins(16'h0010, 8'd6);
        ins(16'h0010, 8'd6);
`ifdef TOPK_DEDUP_EN
        chk("r38_dup_count", bus.count_out, 1);
`else
        chk("r38_dup_count", bus.count_out, 2);
`endif
        // Reset in the middle of a drain.
        clear();
        ins(16'h0501, 8'd1);
        ins(16'h0502, 8'd2);
        ins(16'h0503, 8'd3);
        flush();
        bus.out_ready_in = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("r39_no_done", bus.done_out, 0);
        chk("r39_count", bus.count_out, 0);
        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.clear_in     = $urandom_range(99) < 3;
            bus.ins_valid_in = $urandom_range(99) < 60;
            bus.ins_data_in  = DW'($urandom_range(7));
            bus.ins_tag_in   = TW'($urandom_range(15));
            bus.flush_in     = $urandom_range(99) < 8;
            bus.out_ready_in = $urandom_range(99) < 60;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
